// File: rtl/pipe_stall_ctrl_if.sv
// Stall/flush bus between the pipeline stages and pipe_stall_ctrl.
// Latency: pure wiring; the controller drives the response combinationally.
// Backpressure: stallreq is the backpressure input; stall/bubble/flush carry it to the stages.
interface pipe_stall_ctrl_if #(
  parameter int STAGES = 6
);
  // Requests from the pipeline (bit0 = PC register ... bit STAGES-1 = WB)
  logic [STAGES-1:0] stallreq;
  logic              flush_req;
  logic [31:0]       flush_pc;
  // Controller response
  logic [STAGES-1:0] stall;
  logic [STAGES-1:0] bubble;
  logic [STAGES-1:0] flush;
  logic              redirect_we;
  logic [31:0]       redirect_pc;

  // Pipeline side: raises requests, obeys the stall bus
  modport master (
    output stallreq, flush_req, flush_pc,
    input  stall, bubble, flush, redirect_we, redirect_pc
  );

  // Controller side
  modport slave (
    input  stallreq, flush_req, flush_pc,
    output stall, bubble, flush, redirect_we, redirect_pc
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Merges per-stage stall requests into freeze/bubble vectors; flush overrides. Optional perf counters: PIPE_PERF_CNT_EN.
// Latency: stall/bubble/flush/redirect are combinational (0 cycles); ctrl_state, watchdog and counters are registered.
// Backpressure: the highest requesting stage freezes itself and everything upstream, a bubble enters just below it.
module pipe_stall_ctrl #(
  parameter int          STAGES     = 6,
  parameter int unsigned WDOG_LIMIT = 1024,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stall_ctrl_if.slave bus,
  output logic [1:0]       ctrl_state,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  localparam logic [STAGES-1:0] ONES = '1;
  localparam logic [STAGES-1:0] ONE  = STAGES'(1);
  localparam logic [CNT_W+31:0] LIMIT_W = (CNT_W+32)'(WDOG_LIMIT);

  state_t            state_q;
  logic [CNT_W-1:0]  run_q, run_d;
  logic              timeout_q;
  logic              stall_cyc, flush_cyc;

  logic [STAGES-1:0] stall_c, bubble_c, flush_c;
  logic              redirect_we_c;
  logic [31:0]       redirect_pc_c;

  // Cycle classification; reset masks both so nothing is counted or driven while rst=1
  assign flush_cyc = !rst && bus.flush_req;
  assign stall_cyc = !rst && !bus.flush_req && (|bus.stallreq);

  // Decode requests: the highest requesting stage wins, later loop iterations override earlier ones
  always_comb begin
    stall_c       = '0;
    bubble_c      = '0;
    flush_c       = '0;
    redirect_we_c = 1'b0;
    redirect_pc_c = '0;
    if (flush_cyc) begin
      flush_c       = ONES;
      redirect_we_c = 1'b1;
      redirect_pc_c = bus.flush_pc;
    end else if (stall_cyc) begin
      for (int k = 0; k < STAGES; k++) begin
        if (bus.stallreq[k]) begin
          stall_c  = ONES >> (STAGES - 1 - k);
          // shifting past the top bit leaves zero: no bubble when WB itself stalls
          bubble_c = ONE << (k + 1);
        end
      end
    end
  end

  assign bus.stall       = stall_c;
  assign bus.bubble      = bubble_c;
  assign bus.flush       = flush_c;
  assign bus.redirect_we = redirect_we_c;
  assign bus.redirect_pc = redirect_pc_c;

  // Controller state follows this cycle's outcome; informational only
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else if (flush_cyc) begin
      state_q <= ST_FLUSH;
    end else if (stall_cyc) begin
      state_q <= ST_STALL;
    end else begin
      state_q <= ST_RUN;
    end
  end

  assign ctrl_state = state_q;

  // Consecutive-stall run length, saturating; any non-stall cycle restarts it
  always_comb begin
    run_d = '0;
    if (stall_cyc) begin
      run_d = (&run_q) ? run_q : run_q + 1'b1;
    end
  end

  // Watchdog flag is judged on the updated run length so it rises on the limit-th stalled edge
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      run_q <= run_d;
      if ((CNT_W+32)'(run_d) >= LIMIT_W) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign stall_timeout = timeout_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_cyc && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (flush_cyc && !(&flush_cnt_q)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl (STAGES=6, WDOG_LIMIT=4, CNT_W=4): directed vectors plus a per-cycle reference model.
// Latency: inputs change 1ns after a rising edge, everything is sampled on the falling edge.
// Backpressure: stall requests are driven directly from the stimulus table.
module tb_pipe_stall_ctrl;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int LIM  = 4;
  localparam int CMAX = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] ctrl_state;
  logic       stall_timeout;
  logic [3:0] stall_cnt, flush_cnt;

  pipe_stall_ctrl_if #(.STAGES(6)) bus ();

  pipe_stall_ctrl #(.STAGES(6), .WDOG_LIMIT(LIM), .CNT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .ctrl_state    (ctrl_state),
    .stall_timeout (stall_timeout),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, act, exp);
  endtask

  // Reference model of the registered state, stepped on every rising edge
  int m_state = 0, m_run = 0, m_to = 0, m_scnt = 0, m_fcnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_run = 0; m_to = 0; m_scnt = 0; m_fcnt = 0;
    end else if (bus.flush_req) begin
      m_state = 2; m_run = 0;
      if (PERF && m_fcnt < CMAX) m_fcnt++;
    end else if (bus.stallreq != 0) begin
      m_state = 1;
      if (m_run < CMAX) m_run++;
      if (m_run >= LIM) m_to = 1;
      if (PERF && m_scnt < CMAX) m_scnt++;
    end else begin
      m_state = 0; m_run = 0;
    end
  end

  // Every falling edge: derive the combinational response from the rules and compare everything
  always @(negedge clk) begin
    int h, e_stall, e_bub, e_flush, e_we, e_pc;
    if (chk_en) begin
      e_stall = 0; e_bub = 0; e_flush = 0; e_we = 0; e_pc = 0;
      if (!rst) begin
        if (bus.flush_req) begin
          e_flush = 63; e_we = 1; e_pc = bus.flush_pc;
        end else if (bus.stallreq != 0) begin
          h = 0;
          for (int i = 0; i < 6; i++) if (bus.stallreq[i]) h = i;
          e_stall = (1 << (h + 1)) - 1;
          e_bub   = (h + 1 < 6) ? (1 << (h + 1)) : 0;
        end
      end
      chk("m_stall",   32'(bus.stall),       e_stall);
      chk("m_bubble",  32'(bus.bubble),      e_bub);
      chk("m_flush",   32'(bus.flush),       e_flush);
      chk("m_redir_we", 32'(bus.redirect_we), e_we);
      chk("m_redir_pc", bus.redirect_pc,     e_pc);
      chk("m_state",   32'(ctrl_state),      m_state);
      chk("m_timeout", 32'(stall_timeout),   m_to);
      chk("m_stall_cnt", 32'(stall_cnt),     m_scnt);
      chk("m_flush_cnt", 32'(flush_cnt),     m_fcnt);
    end
  end

  task automatic cyc(input logic r, input logic [5:0] sr, input logic fr, input logic [31:0] pc);
    @(posedge clk);
    #1;
    rst          = r;
    bus.stallreq = sr;
    bus.flush_req = fr;
    bus.flush_pc = pc;
    @(negedge clk);
  endtask

  typedef struct {
    logic [5:0] sr;
    logic [5:0] stall;
    logic [5:0] bub;
  } vec_t;

  vec_t vt[4];

  initial begin
    bus.stallreq  = 6'b001000;
    bus.flush_req = 1'b0;
    bus.flush_pc  = '0;

    // Reset two cycles with a request pending
    cyc(1'b1, 6'b001000, 1'b0, 32'h0);
    chk_en = 1'b1;
    cyc(1'b1, 6'b001000, 1'b0, 32'h0);
    chk("rst_stall",     32'(bus.stall),     32'h0);
    chk("rst_bubble",    32'(bus.bubble),    32'h0);
    chk("rst_state",     32'(ctrl_state),    32'h0);
    chk("rst_timeout",   32'(stall_timeout), 32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt),     32'h0);
    chk("rst_flush_cnt", 32'(flush_cnt),     32'h0);

    // ID load-use stall
    cyc(1'b0, 6'b000100, 1'b0, 32'h0);
    chk("ld_use_stall",  32'(bus.stall),  32'h07);
    chk("ld_use_bubble", 32'(bus.bubble), 32'h08);
    cyc(1'b0, 6'b000000, 1'b0, 32'h0);
    chk("ld_use_state",  32'(ctrl_state), 32'h1);
    chk("ld_use_cnt",    32'(stall_cnt),  PERF ? 32'd1 : 32'd0);

    // Highest requester wins; WB stall has no bubble
    cyc(1'b0, 6'b001100, 1'b0, 32'h0);
    chk("h3_stall",  32'(bus.stall),  32'h0F);
    chk("h3_bubble", 32'(bus.bubble), 32'h10);
    cyc(1'b0, 6'b100000, 1'b0, 32'h0);
    chk("wb_stall",  32'(bus.stall),  32'h3F);
    chk("wb_bubble", 32'(bus.bubble), 32'h00);

    // Flush beats a simultaneous stall
    cyc(1'b0, 6'b001000, 1'b1, 32'hBFC00380);
    chk("fl_stall", 32'(bus.stall),       32'h0);
    chk("fl_flush", 32'(bus.flush),       32'h3F);
    chk("fl_we",    32'(bus.redirect_we), 32'h1);
    chk("fl_pc",    bus.redirect_pc,      32'hBFC00380);
    cyc(1'b0, 6'b000000, 1'b0, 32'h0);
    chk("fl_state",     32'(ctrl_state), 32'h2);
    chk("fl_flush_cnt", 32'(flush_cnt),  PERF ? 32'd1 : 32'd0);
    chk("fl_stall_cnt", 32'(stall_cnt),  PERF ? 32'd3 : 32'd0);
    chk("fl_redir_off", 32'(bus.redirect_we), 32'h0);

    // Watchdog: four consecutive stalled edges
    for (int i = 0; i < 4; i++) cyc(1'b0, 6'b000100, 1'b0, 32'h0);
    chk("wd_before", 32'(stall_timeout), 32'h0);
    cyc(1'b0, 6'b000000, 1'b0, 32'h0);
    chk("wd_set", 32'(stall_timeout), 32'h1);
    cyc(1'b0, 6'b000000, 1'b1, 32'h1234);
    cyc(1'b0, 6'b000000, 1'b0, 32'h0);
    chk("wd_sticky", 32'(stall_timeout), 32'h1);

    // Counter saturation
    for (int i = 0; i < 20; i++) cyc(1'b0, 6'b000010, 1'b0, 32'h0);
    cyc(1'b0, 6'b000000, 1'b0, 32'h0);
    chk("sat_stall_cnt", 32'(stall_cnt), PERF ? 32'hF : 32'h0);

    // Reset asserted mid-stall
    cyc(1'b0, 6'b000100, 1'b0, 32'h0);
    cyc(1'b1, 6'b000100, 1'b1, 32'hDEADBEEF);
    chk("mrst_stall", 32'(bus.stall),       32'h0);
    chk("mrst_flush", 32'(bus.flush),       32'h0);
    chk("mrst_we",    32'(bus.redirect_we), 32'h0);
    cyc(1'b0, 6'b000000, 1'b0, 32'h0);
    chk("mrst_state",   32'(ctrl_state),    32'h0);
    chk("mrst_timeout", 32'(stall_timeout), 32'h0);
    chk("mrst_cnt",     32'(stall_cnt),     32'h0);

    // Directed decode table
    vt[0] = '{6'b000001, 6'b000001, 6'b000010};
    vt[1] = '{6'b010000, 6'b011111, 6'b100000};
    vt[2] = '{6'b101010, 6'b111111, 6'b000000};
    vt[3] = '{6'b000010, 6'b000011, 6'b000100};
    foreach (vt[i]) begin
      cyc(1'b0, vt[i].sr, 1'b0, 32'h0);
      chk("tbl_stall",  32'(bus.stall),  32'(vt[i].stall));
      chk("tbl_bubble", 32'(bus.bubble), 32'(vt[i].bub));
    end

    // Mixed traffic, checked by the model only
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, 6'($urandom_range(0, 63) & (($urandom_range(0, 2) == 0) ? 0 : 63)),
          1'($urandom_range(0, 5) == 0), $urandom);
    end
    cyc(1'b0, 6'b000000, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
